sid_filter_seq: RTL and testbench

Multi-cycle sequencer for the SID state-variable filter. It replaces the single-cycle datapath with one shared signed multiplier that is time-multiplexed across the four products of each sample: band*res, high*fc, band*fc and mix*vol. It sits between the voice generators and the audio output. One sample_stb per audio sample starts a fixed 4-cycle schedule, which ends in an audio_out update and an out_valid pulse.

---
 rtl/sid_pkg.sv | 11 +
 rtl/sid_filter_seq_if.sv | 23 ++
 rtl/sid_mul_shared.sv | 34 +++
 rtl/sid_filter_seq.sv | 119 +++++++++++
 tb/tb_sid_filter_seq.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/sid_pkg.sv
// Shared types and defaults for the multi-cycle SID filter sequencer.
package sid_pkg;
    localparam int STATE_W   = 32;
    localparam int FC_OFFSET = 64;
    localparam int RES_STEP  = 10;
    localparam int COEF_W    = 12;

    typedef logic signed [STATE_W-1:0] state_t;

    typedef enum logic [2:0] {IDLE, RES, BAND, LOW, VOL} seq_state_e;
endpackage

// File: rtl/sid_filter_seq_if.sv
// Sample request, register fields and audio result of the filter sequencer.
interface sid_filter_seq_if;
    logic        sample_stb;
    logic [11:0] v_0, v_1, v_2;
    logic [10:0] reg_fc;
    logic [3:0]  reg_res;
    logic [3:0]  reg_en;
    logic        reg_off3, reg_hp, reg_bp, reg_lp;
    logic [3:0]  reg_vol;
    logic [15:0] audio_out;
    logic        out_valid, busy, overrun;

    modport master (
        output sample_stb, v_0, v_1, v_2, reg_fc, reg_res, reg_en,
               reg_off3, reg_hp, reg_bp, reg_lp, reg_vol,
        input  audio_out, out_valid, busy, overrun
    );
    modport slave (
        input  sample_stb, v_0, v_1, v_2, reg_fc, reg_res, reg_en,
               reg_off3, reg_hp, reg_bp, reg_lp, reg_vol,
        output audio_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/sid_mul_shared.sv
// The single signed multiplier; the schedule state picks which operand pair feeds it.
module sid_mul_shared
    import sid_pkg::*;
#(
    parameter int STATE_W = sid_pkg::STATE_W
) (
    input  seq_state_e                  sel,
    input  logic signed [STATE_W-1:0]   band,
    input  logic signed [STATE_W-1:0]   hn,
    input  logic signed [STATE_W-1:0]   bn,
    input  logic [15:0]                 mixc,
    input  logic [COEF_W-1:0]           res,
    input  logic [COEF_W-1:0]           fc,
    input  logic [3:0]                  vol,
    output logic signed [STATE_W+COEF_W:0] prod
);
    logic signed [STATE_W-1:0] a;
    logic [COEF_W-1:0]         b;

    always_comb begin
        a = '0;
        b = '0;
        case (sel)
            RES:  begin a = band; b = res; end
            BAND: begin a = hn;   b = fc;  end
            LOW:  begin a = bn;   b = fc;  end
            VOL:  begin a = {{(STATE_W-16){1'b0}}, mixc}; b = {{(COEF_W-4){1'b0}}, vol}; end
            default: ;
        endcase
    end

    // B is a magnitude, so a zero sign bit keeps the product signed-correct.
    assign prod = a * $signed({1'b0, b});
endmodule

// File: rtl/sid_filter_seq.sv
// SID state-variable filter run as a 4-cycle schedule over one shared multiplier.
module sid_filter_seq
    import sid_pkg::*;
#(
    parameter int STATE_W   = sid_pkg::STATE_W,
    parameter int FC_OFFSET = sid_pkg::FC_OFFSET,
    parameter int RES_STEP  = sid_pkg::RES_STEP
) (
    input  logic             clk,
    input  logic             n_reset,
    sid_filter_seq_if.slave  bus
);
    localparam int MW = STATE_W + 2;

    seq_state_e                  state;
    logic signed [STATE_W-1:0]   low, band, high;
    logic signed [STATE_W-1:0]   hn, bn, ln;
    logic signed [STATE_W-1:0]   filt;
    logic [15:0]                 mixc;
    logic [COEF_W-1:0]           fc_c, res_c;
    logic [3:0]                  vol_c;
    logic signed [STATE_W+COEF_W:0] prod;

    logic [13:0]                 filt_sum, dir_sum;
    logic signed [MW-1:0]        mix_w;
    logic [15:0]                 mix_clamp;
    logic                        unused_en3;

    assign unused_en3 = bus.reg_en[3];

    always_comb begin
        filt_sum = (bus.reg_en[0] ? 14'(bus.v_0) : 14'd0)
                 + (bus.reg_en[1] ? 14'(bus.v_1) : 14'd0)
                 + (bus.reg_en[2] ? 14'(bus.v_2) : 14'd0);
        dir_sum  = (!bus.reg_en[0] ? 14'(bus.v_0) : 14'd0)
                 + (!bus.reg_en[1] ? 14'(bus.v_1) : 14'd0)
                 + ((!bus.reg_en[2] && !bus.reg_off3) ? 14'(bus.v_2) : 14'd0);
        // Mix taps the committed state, which gives one sample of filter latency.
        mix_w = MW'(dir_sum)
              + (bus.reg_lp ? MW'(low)  : MW'(0))
              + (bus.reg_bp ? MW'(band) : MW'(0))
              + (bus.reg_hp ? MW'(high) : MW'(0));
        if (mix_w < 0)
            mix_clamp = 16'd0;
        else if (mix_w > 65535)
            mix_clamp = 16'hffff;
        else
            mix_clamp = mix_w[15:0];
    end

    sid_mul_shared #(.STATE_W(STATE_W)) u_mul (
        .sel  (state),
        .band (band),
        .hn   (hn),
        .bn   (bn),
        .mixc (mixc),
        .res  (res_c),
        .fc   (fc_c),
        .vol  (vol_c),
        .prod (prod)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state         <= IDLE;
            low           <= '0;
            band          <= '0;
            high          <= '0;
            hn            <= '0;
            bn            <= '0;
            ln            <= '0;
            filt          <= '0;
            mixc          <= '0;
            fc_c          <= '0;
            res_c         <= '0;
            vol_c         <= '0;
            bus.audio_out <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.overrun   <= bus.sample_stb && (state != IDLE);
            case (state)
                IDLE: if (bus.sample_stb) begin
                    filt     <= STATE_W'(filt_sum);
                    mixc     <= mix_clamp;
                    fc_c     <= COEF_W'(int'(bus.reg_fc) + FC_OFFSET);
                    res_c    <= COEF_W'(256 - RES_STEP * int'(bus.reg_res));
                    vol_c    <= bus.reg_vol;
                    bus.busy <= 1'b1;
                    state    <= RES;
                end
                RES: begin
                    hn    <= filt - low - STATE_W'(prod >>> 8);
                    state <= BAND;
                end
                BAND: begin
                    bn    <= band + STATE_W'(prod >>> 16);
                    state <= LOW;
                end
                LOW: begin
                    ln    <= low + STATE_W'(prod >>> 16);
                    state <= VOL;
                end
                VOL: begin
                    bus.audio_out <= 16'(prod >>> 4);
                    high          <= hn;
                    band          <= bn;
                    low           <= ln;
                    bus.out_valid <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sid_filter_seq.sv
// Directed bench for sid_filter_seq: scoreboard of expected samples popped on out_valid.
module tb_sid_filter_seq;
    logic clk = 1'b0;
    logic n_reset;

    sid_filter_seq_if bus();

    sid_filter_seq dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every out_valid consumes one expected sample.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            int e;
            nvalid++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            chk("audio_out", {48'd0, bus.audio_out}, 64'(e));
        end
    end

    task automatic cfg(input logic [3:0] en, input int v0, input int v1, input int v2,
                       input logic off3, input logic hp, input logic bp, input logic lp,
                       input int fc, input int res, input int vol);
        bus.reg_en   = en;
        bus.v_0      = 12'(v0);
        bus.v_1      = 12'(v1);
        bus.v_2      = 12'(v2);
        bus.reg_off3 = off3;
        bus.reg_hp   = hp;
        bus.reg_bp   = bp;
        bus.reg_lp   = lp;
        bus.reg_fc   = 11'(fc);
        bus.reg_res  = 4'(res);
        bus.reg_vol  = 4'(vol);
    endtask

    task automatic strobe();
        @(negedge clk);
        bus.sample_stb = 1'b1;
        @(posedge clk);
        #1 bus.sample_stb = 1'b0;
    endtask

    task automatic sample(input int e);
        exp_q.push_back(e);
        strobe();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        n_reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    initial begin
        n_reset        = 1'b0;
        bus.sample_stb = 1'b0;
        cfg(4'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_audio", {48'd0, bus.audio_out}, 64'd0);
        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_busy",  {63'd0, bus.busy}, 64'd0);
        chk("rst_overrun", {63'd0, bus.overrun}, 64'd0);
        @(negedge clk);
        n_reset = 1'b1;

        // Reset during BAND aborts the sample without an output.
        cfg(4'd0, 100, 200, 300, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 15);
        strobe();
        @(posedge clk);
        #1 n_reset = 1'b0;
        #1 chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        repeat (6) @(posedge clk);
        #1 chk("abort_no_valid", 64'(nvalid), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;

        // Bypass path, with a cycle-by-cycle look at busy and the output pulse.
        exp_q.push_back(562);
        strobe();
        chk("busy_e0", {63'd0, bus.busy}, 64'd1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1 chk("busy_run", {63'd0, bus.busy}, 64'd1);
            chk("valid_early", {63'd0, bus.out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;
        chk("busy_e4", {63'd0, bus.busy}, 64'd0);
        chk("valid_e4", {63'd0, bus.out_valid}, 64'd1);
        chk("audio_e4", {48'd0, bus.audio_out}, 64'd562);
        @(posedge clk);
        #1 chk("valid_single", {63'd0, bus.out_valid}, 64'd0);
        repeat (2) @(posedge clk);

        cfg(4'd0, 100, 200, 300, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 15);
        sample(281);
        cfg(4'd0, 100, 200, 300, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        sample(0);

        // Band-pass build-up from zero state.
        cfg(4'd1, 4095, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 15);
        sample(0);
        chk("bp_band1", 64'(dut.band), 64'd3);
        chk("bp_low1",  64'(dut.low),  64'd0);
        repeat (2) @(posedge clk);
        sample(2);
        chk("bp_band2", 64'(dut.band), 64'd6);
        chk("bp_low2",  64'(dut.low),  64'd0);

        // High-pass from a clean state.
        pulse_reset();
        cfg(4'd7, 4095, 4095, 4095, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 15);
        sample(0);
        sample(11517);

        // Overrun: second strobe dropped, changes during busy ignored.
        pulse_reset();
        cfg(4'd0, 100, 200, 300, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 15);
        exp_q.push_back(562);
        strobe();
        @(negedge clk);
        bus.sample_stb = 1'b1;
        bus.v_0        = 12'd4095;
        bus.reg_vol    = 4'd0;
        @(posedge clk);
        #1 bus.sample_stb = 1'b0;
        chk("ovr_pulse", {63'd0, bus.overrun}, 64'd1);
        chk("ovr_busy",  {63'd0, bus.busy}, 64'd1);
        @(posedge clk);
        #1 chk("ovr_clear", {63'd0, bus.overrun}, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("ovr_idle", {63'd0, bus.busy}, 64'd0);

        chk("valid_count", 64'(nvalid), 64'd8);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
